usb_spi_target: RTL and testbench

//   SPI target (slave) that answers the SPI master inside the USB serial device; it is the far end of spi_csel/spi_clk/spi_mosi/spi_miso.

---
 rtl/usb_spi_target.sv | 171 +++++++++++++++++
 tb/tb_usb_spi_target.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_spi_target.sv
// SPI mode-0 target that oversamples the SPI pins in the 48 MHz domain.
// Received bytes leave on a valid/ready stream; reply bytes come from a valid/ready stream and go out on MISO.
module usb_spi_target #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       spi_csel,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       overrun,
    output logic       underrun,
    input  logic       clear_status
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] csel_sync_q, sck_sync_q, mosi_sync_q;
    logic                   csel_prev_q, sck_prev_q;
    logic                   csel_s, sck_s, mosi_s;
    logic                   csel_fall, csel_rise, sck_rise, sck_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic        first_q, first_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        underrun_q, underrun_d;
    logic        overrun_set, underrun_set;
    logic [7:0]  load_byte;

    // Synchronisers reset to the idle pin levels so no spurious edge appears after reset.
    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            csel_sync_q <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            csel_prev_q <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            csel_sync_q <= {csel_sync_q[SYNC_STAGES-2:0], spi_csel};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            csel_prev_q <= csel_sync_q[SYNC_STAGES-1];
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign csel_s    = csel_sync_q[SYNC_STAGES-1];
    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csel_fall = csel_prev_q & ~csel_s;
    assign csel_rise = ~csel_prev_q & csel_s;
    assign sck_rise  = ~sck_prev_q & sck_s;
    assign sck_fall  = sck_prev_q & ~sck_s;

    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            first_q     <= 1'b0;
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            first_q     <= first_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        first_d      = first_q;
        miso_d       = miso_q;
        oe_d         = ~csel_s;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q && !rx_ready;
        overrun_set  = 1'b0;
        underrun_set = 1'b0;
        load_byte    = tx_valid ? tx_data : IDLE_BYTE;

        case (state_q)
            IDLE: begin
                if (csel_fall) begin
                    state_d = LOAD;
                    first_d = 1'b1;
                end
            end
            LOAD: begin
                underrun_set = !tx_valid;
                bit_cnt_d    = '0;
                state_d      = SHIFT;
                // The first byte of a frame has no leading SCK fall, so its MSB goes out right away.
                if (first_q) begin
                    miso_d      = load_byte[7];
                    shift_out_d = {load_byte[6:0], 1'b0};
                end else begin
                    shift_out_d = load_byte;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    shift_in_d = {shift_in_q[5:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = {shift_in_q, mosi_s};
                        rx_valid_d  = 1'b1;
                        overrun_set = rx_valid_q && !rx_ready;
                        first_d     = 1'b0;
                        state_d     = LOAD;
                    end
                end else if (sck_fall && !(first_q && bit_cnt_q == 3'd0)) begin
                    miso_d      = shift_out_q[7];
                    shift_out_d = {shift_out_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        if (csel_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b1;
        end

        overrun_d  = clear_status ? 1'b0 : (overrun_q | overrun_set);
        underrun_d = clear_status ? 1'b0 : (underrun_q | underrun_set);
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_usb_spi_target.sv
// Randomised bench for usb_spi_target: a bit-banged SPI master, a tx byte queue and an rx scoreboard.
module tb_usb_spi_target;

    localparam int SYNC = 2;

    logic       clk_48mhz = 1'b0;
    logic       reset = 1'b0;
    logic       spi_csel = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, overrun, underrun;
    logic       clear_status = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         halfCycles = 12;
    logic [7:0] txQ[$];
    logic [7:0] expRxQ[$];
    bit         expOverrun = 1'b0;
    bit         expUnderrun = 1'b0;
    bit         hsPending = 1'b0;
    logic [7:0] mosiBuf[8];

    always #10 clk_48mhz = ~clk_48mhz;

    usb_spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .spi_csel    (spi_csel),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .overrun     (overrun),
        .underrun    (underrun),
        .clear_status(clear_status)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx handshake is scored against the oldest expected byte.
    always @(negedge clk_48mhz) begin
        hsPending = tx_ready && tx_valid;
        if (reset && rx_valid && rx_ready) begin
            if (expRxQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rxUnexpected: got %0h expected no byte", rx_data);
            end else begin
                checkOutput("rxByte", rx_data, expRxQ.pop_front());
            end
        end
    end

    // Reply source: presents the head of txQ and retires it after a handshake.
    always @(posedge clk_48mhz) begin
        #1;
        if (hsPending && txQ.size() > 0) void'(txQ.pop_front());
        hsPending = 1'b0;
        tx_valid  = (txQ.size() > 0);
        tx_data   = (txQ.size() > 0) ? txQ[0] : 8'h00;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_48mhz);
        #3;
    endtask

    task automatic sendBits(input logic [7:0] b, input int nbits, input bit accPulse, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            waitCycles(halfCycles);
            got = {got[6:0], spi_miso};
            spi_clk = 1'b1;
            if (accPulse && i == 7) begin
                // The byte completes SYNC+1 clocks after the pin edge; accept the older byte on exactly that clock.
                @(posedge clk_48mhz);
                @(posedge clk_48mhz);
                #1 rx_ready = 1'b1;
                @(posedge clk_48mhz);
                #1 rx_ready = 1'b0;
                waitCycles(halfCycles - 3);
            end else begin
                waitCycles(halfCycles);
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic clearStatus();
        @(posedge clk_48mhz);
        #3 clear_status = 1'b1;
        @(posedge clk_48mhz);
        #3 clear_status = 1'b0;
        expOverrun  = 1'b0;
        expUnderrun = 1'b0;
        checkOutput("statusCleared", {30'd0, overrun, underrun}, 32'd0);
    endtask

    // One chip-select frame: nBytes full bytes, optionally a partial byte, then csel release.
    task automatic applyStimulus(input int nBytes, input int partialBits, input bit rxHold, input bit accOn2nd);
        logic [7:0] txSnap[$];
        logic [7:0] got;
        logic [7:0] expMiso;
        int         loads;
        int         remain;
        txSnap   = txQ;
        loads    = nBytes + 1;
        remain   = (txSnap.size() > loads) ? txSnap.size() - loads : 0;
        if (txSnap.size() < loads) expUnderrun = 1'b1;
        rx_ready = !rxHold;
        spi_csel = 1'b0;
        for (int k = 0; k < nBytes; k++) begin
            if (rxHold && !(accOn2nd && k == 1) && expRxQ.size() > 0) begin
                void'(expRxQ.pop_back());
                expOverrun = 1'b1;
            end
            expRxQ.push_back(mosiBuf[k]);
            expMiso = (k < txSnap.size()) ? txSnap[k] : 8'hFF;
            sendBits(mosiBuf[k], 8, accOn2nd && k == 1, got);
            checkOutput("misoByte", got, expMiso);
            checkOutput("misoOeOn", spi_miso_oe, 1);
        end
        if (partialBits > 0) sendBits(mosiBuf[nBytes], partialBits, 1'b0, got);
        waitCycles(halfCycles);
        spi_csel = 1'b1;
        repeat (SYNC + 2) @(posedge clk_48mhz);
        #1;
        checkOutput("misoOeOff", spi_miso_oe, 0);
        checkOutput("misoIdle", spi_miso, 1);
        waitCycles(4);
        checkOutput("busyIdle", busy, 0);
        checkOutput("txConsumed", txQ.size(), remain);
        checkOutput("underrun", underrun, expUnderrun);
        checkOutput("overrun", overrun, expOverrun);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Miso"}, spi_miso, 1);
        checkOutput({tag, "Oe"}, spi_miso_oe, 0);
        checkOutput({tag, "RxData"}, rx_data, 0);
        checkOutput({tag, "RxValid"}, rx_valid, 0);
        checkOutput({tag, "TxReady"}, tx_ready, 0);
        checkOutput({tag, "Busy"}, busy, 0);
        checkOutput({tag, "Status"}, {30'd0, overrun, underrun}, 0);
    endtask

    initial begin
        int         n;
        int         m;
        logic [7:0] got;

        repeat (3) @(posedge clk_48mhz);
        #1 checkResetValues("reset");
        waitCycles(1);
        reset = 1'b1;
        waitCycles(4);

        // Single byte at 2 MHz SCK, one reply byte queued.
        txQ.delete();
        txQ.push_back(8'h3C);
        mosiBuf[0] = 8'hA5;
        waitCycles(2);
        applyStimulus(1, 0, 1'b0, 1'b0);
        clearStatus();

        // Four-byte burst with no reply data available.
        txQ.delete();
        for (int i = 0; i < 4; i++) mosiBuf[i] = 8'(i + 1);
        waitCycles(2);
        applyStimulus(4, 0, 1'b0, 1'b0);
        clearStatus();

        // Consumer stalled across two bytes: newest byte wins and overrun sets.
        mosiBuf[0] = 8'h11;
        mosiBuf[1] = 8'h22;
        applyStimulus(2, 0, 1'b1, 1'b0);
        checkOutput("rxNewestWins", rx_data, expRxQ[0]);
        clearStatus();
        rx_ready = 1'b1;
        waitCycles(3);
        checkOutput("rxDrained", expRxQ.size(), 0);

        // Frame aborted after five bits, then a clean byte.
        txQ.delete();
        txQ.push_back(8'($urandom));
        mosiBuf[0] = 8'($urandom);
        waitCycles(2);
        applyStimulus(0, 5, 1'b0, 1'b0);
        checkOutput("rxNoPartial", expRxQ.size(), 0);
        clearStatus();
        txQ.delete();
        txQ.push_back(8'($urandom));
        mosiBuf[0] = 8'h5A;
        waitCycles(2);
        applyStimulus(1, 0, 1'b0, 1'b0);
        clearStatus();

        // Accept lands on the same clock as the second byte completing.
        txQ.delete();
        for (int i = 0; i < 3; i++) txQ.push_back(8'($urandom));
        mosiBuf[0] = 8'h33;
        mosiBuf[1] = 8'h44;
        waitCycles(2);
        applyStimulus(2, 0, 1'b1, 1'b1);
        checkOutput("rxValidHeld", rx_valid, 1);
        checkOutput("rxSecond", rx_data, 8'h44);
        rx_ready = 1'b1;
        waitCycles(3);
        checkOutput("rxDrained2", expRxQ.size(), 0);
        clearStatus();

        // Reset asserted in the middle of a byte.
        txQ.delete();
        txQ.push_back(8'h77);
        waitCycles(2);
        spi_csel = 1'b0;
        sendBits(8'hC3, 4, 1'b0, got);
        reset = 1'b0;
        #1 checkResetValues("midReset");
        spi_csel = 1'b1;
        txQ.delete();
        expRxQ.delete();
        expOverrun  = 1'b0;
        expUnderrun = 1'b0;
        waitCycles(3);
        reset = 1'b1;
        waitCycles(4);
        txQ.push_back(8'h81);
        mosiBuf[0] = 8'hC3;
        waitCycles(2);
        applyStimulus(1, 0, 1'b0, 1'b0);

        // Random frames: random SCK rate, length and reply-queue depth.
        for (int it = 0; it < 8; it++) begin
            clearStatus();
            halfCycles = $urandom_range(6, 14);
            n = $urandom_range(1, 4);
            m = $urandom_range(0, n + 1);
            for (int i = 0; i < n; i++) mosiBuf[i] = 8'($urandom);
            txQ.delete();
            for (int i = 0; i < m; i++) txQ.push_back(8'($urandom));
            waitCycles(2);
            applyStimulus(n, 0, 1'b0, 1'b0);
        end

        waitCycles(5);
        checkOutput("rxDrainedEnd", expRxQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] timeout");
    end

endmodule
